// File: rtl/vga_timing_pkg.sv
// Shared VGA raster definitions: default 640x480@60 timing, totals helpers and
// the coordinate / sync-bundle types used by the timing generator.
package vga_timing_pkg;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    // Counters are 10 bits, so neither total may exceed this.
    localparam int MAX_TOTAL = 1024;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_t;

    function automatic int h_total(input int disp, input int front, input int sync,
                                   input int back);
        return disp + front + sync + back;
    endfunction

    function automatic int v_total(input int disp, input int front, input int sync,
                                   input int back);
        return disp + front + sync + back;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register used to re-align sync/blank with a downstream
// pixel pipeline. DEPTH==0 is a straight wire.
module sync_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, rst_ni, en_i};
        assign q_o         = d_i;
    end else begin : g_pipe
        logic [DEPTH-1:0][WIDTH-1:0] stage_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stage_q <= {DEPTH{RESET_VAL}};
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, registered sync/blank
// decode and a pixel-rate delay line for pipeline-aligned syncs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int H_DISPLAY   = H_DISPLAY_DEF,
    parameter int H_FRONT     = H_FRONT_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BACK      = H_BACK_DEF,
    parameter int V_DISPLAY   = V_DISPLAY_DEF,
    parameter int V_FRONT     = V_FRONT_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BACK      = V_BACK_DEF,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int PIPE_DELAY  = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic       hsync_d,
    output logic       vsync_d,
    output logic       video_on_d
);

    localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_chk
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
        $error("vga_timing_gen: CLK_DIV must be 1..16");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_delay_chk
        $error("vga_timing_gen: PIPE_DELAY must be 0..7");
    end

    localparam logic [3:0] DIV_LAST     = 4'(CLK_DIV - 1);
    localparam coord_t     H_LAST       = coord_t'(H_TOTAL - 1);
    localparam coord_t     V_LAST       = coord_t'(V_TOTAL - 1);
    localparam coord_t     H_VIS        = coord_t'(H_DISPLAY);
    localparam coord_t     V_VIS        = coord_t'(V_DISPLAY);
    localparam coord_t     H_SYNC_FIRST = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t     H_SYNC_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t     V_SYNC_FIRST = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t     V_SYNC_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [3:0] div_q, div_d;
    coord_t     x_q, x_d, y_q, y_d;
    logic       hs_q, hs_d, vs_q, vs_d, von_q, von_d;
    logic       ls_q, ls_d, fs_q, fs_d;
    logic       x_wrap;

    assign p_tick = (div_q == DIV_LAST);
    assign x_wrap = (x_q == H_LAST);

    // Sync/blank decode from the next-state counters so the registered
    // outputs change on the same edge as pix_x/pix_y.
    always_comb begin
        div_d = p_tick ? 4'd0 : div_q + 4'd1;
        x_d   = x_q;
        y_d   = y_q;
        if (p_tick) begin
            x_d = x_wrap ? '0 : x_q + 10'd1;
            if (x_wrap) begin
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end
        end
        hs_d  = (x_d >= H_SYNC_FIRST && x_d <= H_SYNC_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vs_d  = (y_d >= V_SYNC_FIRST && y_d <= V_SYNC_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        von_d = (x_d < H_VIS) && (y_d < V_VIS);
        ls_d  = p_tick && x_wrap;
        fs_d  = p_tick && x_wrap && (y_q == V_LAST);
    end

    // Reset parks the counters on the last pixel so the first tick enters (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= 4'd0;
            x_q   <= H_LAST;
            y_q   <= V_LAST;
            hs_q  <= ~SYNC_ACTIVE;
            vs_q  <= ~SYNC_ACTIVE;
            von_q <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            von_q <= von_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
        end
    end

    sync_t sync_now, sync_dly;

    assign sync_now = '{hsync: hs_q, vsync: vs_q, video_on: von_q};

    sync_delay_line #(
        .WIDTH    (3),
        .DEPTH    (PIPE_DELAY),
        .RESET_VAL({~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0})
    ) u_sync_dly (
        .clk_i (clk),
        .rst_ni(reset),
        .en_i  (p_tick),
        .d_i   (sync_now),
        .q_o   (sync_dly)
    );

    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = von_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign hsync_d     = sync_dly.hsync;
    assign vsync_d     = sync_dly.vsync;
    assign video_on_d  = sync_dly.video_on;

endmodule
